mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS core. Sequences the shared PC, unified
//  memory, register file and ALU over 3-5 cycles per instruction. Handles lw, sw,
//  R-type, beq, addi and j. Emits per-cycle datapath selects and write enables.
//  Stalls on memory via mem_ready and traps on unsupported opcodes.
// PARAMETERS
//  STATE_W  4  width of the state_o debug output (fixed, do not override below 4)
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  reset, asynchronous, active-high
//  opcode      in   6  instr[31:26] from the instruction register
//  funct       in   6  instr[5:0] from the instruction register
//  zero        in   1  ALU zero flag (combinational, same cycle)
//  mem_ready   in   1  memory access completes this cycle
//  iord        out  1  memory address select: 0=PC, 1=ALUOut
//  mem_we      out  1  memory write enable
//  ir_we       out  1  instruction register load
//  pc_we       out  1  PC load (already includes the branch-taken term)
//  reg_we      out  1  register file write enable
//  reg_dst     out  1  register file write address select: 0=rt, 1=rd
//  mem_to_reg  out  1  register file write data select: 0=ALUOut, 1=MDR
//  alu_src_a   out  1  ALU A select: 0=PC, 1=regA
//  alu_src_b   out  2  ALU B select: 00=regB, 01=+4, 10=signext, 11=signext<<2
//  alu_ctrl    out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
//  pc_src      out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
//  illegal     out  1  sticky flag: unsupported opcode or funct decoded
//  state_o     out  4  current state encoding, for debug
// BEHAVIOUR
//  - rst high: state<=FETCH and illegal<=0. All *_we outputs forced 0 while rst is high.
//    Select outputs take the FETCH values.
//  - Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
//  - R-type funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//    Any other funct is illegal.
//  - States, encoding 0-11:
//    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BRANCH,
//    ADDIEXE, ADDIWB, JUMP, ILLEGAL (ILLEGAL encoded as 4'hF).
//  - FETCH: iord=0, src_a=0, src_b=01, alu=add, pc_src=00.
//    ir_we = pc_we = mem_ready. Holds in FETCH until mem_ready=1, then -> DECODE.
//  - DECODE: src_a=0, src_b=11, alu=add (precomputes the branch target).
//    Next state: lw/sw->MEMADR, R->RTEXE, beq->BRANCH, addi->ADDIEXE,
//    j->JUMP, other->ILLEGAL.
//  - MEMADR: src_a=1, src_b=10, add. lw->MEMRD, sw->MEMWR.
//  - MEMRD: iord=1. Holds until mem_ready=1, then -> MEMWB.
//  - MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - MEMWR: iord=1, mem_we=1. Holds until mem_ready=1, then -> FETCH.
//    mem_we stays asserted for every wait cycle.
//  - RTEXE: src_a=1, src_b=00, alu from funct -> RTWB.
//    An illegal funct goes to ILLEGAL instead, and no register write occurs.
//  - RTWB: reg_we=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - BRANCH: src_a=1, src_b=00, sub, pc_src=01, pc_we=zero -> FETCH.
//  - ADDIEXE: src_a=1, src_b=10, add -> ADDIWB.
//  - ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - JUMP: pc_src=10, pc_we=1 -> FETCH.
//  - ILLEGAL: terminal until rst. All write enables are 0. illegal=1.
//  - Outputs not listed for a state are 0. alu_ctrl defaults to add.
//  - Outputs are Moore-style. Exceptions: pc_we/ir_we in FETCH, and pc_we in BRANCH,
//    which also depend on a same-cycle input.
//  - Latency with mem_ready tied to 1:
//    lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
//  - Reset asserted mid-instruction aborts it immediately. No partial write occurs
//    after the rst edge.
// STRUCTURE
//  - Shared package mips_pkg holds the opcode/funct localparams, the alu_ctrl
//    encodings and the state encoding.
//  - One sub-module, mips_alu_decoder: combinational funct -> alu_ctrl + funct_illegal.
//  - The FSM uses a registered state and a combinational next-state/output block.
// TESTING
//  - lw (op 100011), mem_ready=1:
//    states 0,1,2,3,4,0; reg_we=1 and mem_to_reg=1 only in MEMWB; pc_we=1 only in cycle 1.
//  - sw with mem_ready low 3 cycles in MEMWR:
//    mem_we high 4 consecutive cycles, then FETCH; reg_we never asserted.
//  - beq with zero=1 -> pc_we=1, pc_src=01 in BRANCH.
//    With zero=0 -> pc_we=0; both cases return to FETCH.
//  - R-type funct 101010 -> alu_ctrl=111 in RTEXE, reg_dst=1 in RTWB.
//    funct 000111 -> ILLEGAL, illegal=1 sticky, no writes.
//  - Fetch stall: mem_ready=0 for 5 cycles -> state stays FETCH, ir_we=pc_we=0;
//    mem_ready=1 -> both pulse for 1 cycle.
//  - rst asserted in MEMWR mid-stall -> mem_we=0 at once;
//    after release: state FETCH, illegal=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct codes, ALU control encodings and control FSM state encoding
package mips_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEXE = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'hF
  } state_t;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: R-type funct to ALU control, flags unsupported funct codes
//   funct         in  6  instr[5:0]
//   alu_ctrl      out 3  ALU operation (add for unsupported codes)
//   funct_illegal out 1  funct is not one of add/sub/and/or/slt
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_illegal
);
  always_comb begin
    alu_ctrl = funct == FN_ADD ? ALU_ADD :
               funct == FN_SUB ? ALU_SUB :
               funct == FN_AND ? ALU_AND :
               funct == FN_OR  ? ALU_OR  :
               funct == FN_SLT ? ALU_SLT : ALU_ADD;
    funct_illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM sequencing the multicycle MIPS datapath
//   clk, rst (async, active-high); opcode/funct from IR; zero from ALU; mem_ready from memory
//   outputs: memory/IR/PC/regfile write enables, datapath selects, alu_ctrl,
//   sticky illegal flag and state_o debug view of the state register
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               mem_we,
  output logic               ir_we,
  output logic               pc_we,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_ctrl,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);
  state_t     state_q, state_d;
  logic       illegal_q;
  logic [2:0] rt_alu;
  logic       rt_bad;
  mips_alu_decoder u_alu_dec (
    .funct        (funct),
    .alu_ctrl     (rt_alu),
    .funct_illegal(rt_bad)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_ILLEGAL);
    end
  end
  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    pc_src     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        state_d   = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                    opcode == OP_R    ? S_RTEXE   :
                    opcode == OP_BEQ  ? S_BRANCH  :
                    opcode == OP_ADDI ? S_ADDIEXE :
                    opcode == OP_J    ? S_JUMP    : S_ILLEGAL;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord    = 1'b1;
        mem_we  = 1'b1;
        state_d = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        alu_ctrl  = rt_alu;
        state_d   = rt_bad ? S_ILLEGAL : S_RTWB;
      end
      S_RTWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_we     = zero;
        state_d   = S_FETCH;
      end
      S_ADDIEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
    // reset is asynchronous, so the FETCH-state enables must also be masked combinationally
    if (rst) begin
      mem_we = 1'b0;
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
    end
  end
  assign illegal = illegal_q;
  assign state_o = STATE_W'(state_q);
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven scoreboard bench for the multicycle control FSM
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010, BAD = 6'b111111;
  localparam logic [2:0] A = 3'b010;
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic        r;
    logic [19:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic iord, mem_we, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;
  logic [19:0] got;
  vec_t tv[$];
  logic [19:0] exp_q[$];
  int checks = 0, errors = 0;
  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .pc_src(pc_src), .illegal(illegal), .state_o(state_o)
  );
  always #5 clk = ~clk;
  assign got = {state_o, iord, mem_we, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, alu_ctrl, pc_src, illegal};
  function automatic logic [19:0] o(input logic [3:0] st, input logic io, mw, irw, pcw, rw, rd,
                                    m2r, sa, input logic [1:0] sb, input logic [2:0] alu,
                                    input logic [1:0] ps, input logic ill);
    return {st, io, mw, irw, pcw, rw, rd, m2r, sa, sb, alu, ps, ill};
  endfunction
  task automatic add(input logic [5:0] op, fn, input logic z, rdy, r, input logic [19:0] e);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.r = r; v.exp = e;
    tv.push_back(v);
  endtask
  task automatic fetch(input logic [5:0] op, fn);
    add(op, fn, 0, 1, 0, o(0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, A, 2'b00, 0));
    add(op, fn, 0, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, A, 2'b00, 0));
  endtask
  task automatic rtype(input logic [5:0] fn, input logic [2:0] alu);
    fetch(RT, fn);
    add(RT, fn, 0, 1, 0, o(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 2'b00, 0));
    add(RT, fn, 0, 1, 0, o(7, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, A, 2'b00, 0));
  endtask
  task automatic lat(input logic [5:0] op, fn, input int exp_n);
    int n;
    n = 0;
    opcode = op; funct = fn; zero = 1'b0; mem_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
      @(posedge clk);
      #1;
    end while (state_o != 4'd0 && n < 20);
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL latency op=%b got %0d cycles expected %0d", op, n, exp_n);
    end
  endtask
  initial begin
    logic [19:0] e;
    add(LW, 0, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, A, 2'b00, 0));
    fetch(LW, 0);
    add(LW, 0, 0, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A, 2'b00, 0));
    add(LW, 0, 0, 0, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, A, 2'b00, 0));
    add(LW, 0, 0, 1, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, A, 2'b00, 0));
    add(LW, 0, 0, 1, 0, o(4, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, A, 2'b00, 0));
    fetch(SW, 0);
    add(SW, 0, 0, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A, 2'b00, 0));
    for (int i = 0; i < 3; i++) add(SW, 0, 0, 0, 0, o(5, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, A, 2'b00, 0));
    add(SW, 0, 0, 1, 0, o(5, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, A, 2'b00, 0));
    rtype(6'b101010, 3'b111);
    rtype(6'b100010, 3'b110);
    rtype(6'b100100, 3'b000);
    rtype(6'b100101, 3'b001);
    rtype(6'b100000, 3'b010);
    fetch(BQ, 0);
    add(BQ, 0, 1, 1, 0, o(8, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0));
    fetch(BQ, 0);
    add(BQ, 0, 0, 1, 0, o(8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0));
    fetch(AI, 0);
    add(AI, 0, 0, 1, 0, o(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A, 2'b00, 0));
    add(AI, 0, 0, 1, 0, o(10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, A, 2'b00, 0));
    for (int i = 0; i < 5; i++) add(JP, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, A, 2'b00, 0));
    fetch(JP, 0);
    add(JP, 0, 0, 1, 0, o(11, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, A, 2'b10, 0));
    fetch(SW, 0);
    add(SW, 0, 0, 1, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A, 2'b00, 0));
    add(SW, 0, 0, 0, 0, o(5, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, A, 2'b00, 0));
    add(SW, 0, 0, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, A, 2'b00, 0));
    fetch(RT, 6'b000111);
    add(RT, 6'b000111, 0, 1, 0, o(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, A, 2'b00, 0));
    for (int i = 0; i < 3; i++) add(RT, 6'b000111, 1, 1, 0, o(15, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, A, 2'b00, 1));
    add(RT, 0, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, A, 2'b00, 0));
    fetch(BAD, 0);
    add(BAD, 0, 0, 1, 0, o(15, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, A, 2'b00, 1));
    add(BAD, 0, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, A, 2'b00, 0));
    add(LW, 0, 0, 1, 0, o(0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, A, 2'b00, 0));
    @(posedge clk);
    #1;
    foreach (tv[i]) begin
      opcode = tv[i].op; funct = tv[i].fn; zero = tv[i].z;
      mem_ready = tv[i].rdy; rst = tv[i].r;
      exp_q.push_back(tv[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL row %0d st/we/sel got %b expected %b", i, got, e);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    rst = 1'b0;
    lat(LW, 0, 5);
    lat(SW, 0, 4);
    lat(RT, 6'b100000, 4);
    lat(AI, 0, 4);
    lat(BQ, 0, 3);
    lat(JP, 0, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
